// File: rtl/demux_main_pkg.sv
// demux_main_pkg -- shared definitions for the 1:4 byte demux.
//   LANES            : number of output lanes (bytes per group)
//   FLUSH_CYCLES_DEF : default idle-cycle limit before a partial group flushes
//   state_t          : staging FSM encoding (EMPTY / FILL)
package demux_main_pkg;
    localparam int LANES            = 4;
    localparam int FLUSH_CYCLES_DEF = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,   // idx = 0, nothing staged
        ST_FILL  = 1'b1    // 1..3 bytes staged
    } state_t;
endpackage

// File: rtl/demux_main_flush_timer.sv
// demux_flush_timer -- counts consecutive idle cycles of a partially filled
// group. Only compiled when DEMUX_FLUSH_EN is defined.
//   clk     : clock
//   reset   : synchronous active-high reset
//   clear   : zero the count (byte accepted or flush taken)
//   enable  : count this cycle (in FILL with no byte)
//   expired : count has reached FLUSH_CYCLES
`ifdef DEMUX_FLUSH_EN
module demux_flush_timer #(
    parameter int FLUSH_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count;

    assign expired = (count == 8'(FLUSH_CYCLES));

    // Saturates at the limit; the top clears it when the flush is taken.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end
endmodule
`endif

// File: rtl/demux_main.sv
// demux_main -- collects a serialized byte stream into groups of four and
// presents each group on four registered lanes for one cycle.
// Optional feature macro: DEMUX_FLUSH_EN -- flush a partial group after
// FLUSH_CYCLES idle cycles (flushed pulses with it).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   valid_in, data_in       : input byte stream (one byte per cycle, no stall)
//   data_out0..3            : lane k = k-th byte of the group (held when idle)
//   valid_out0..3           : lane k valid for the single emission cycle
//   flushed                 : emission was a timeout flush of a partial group
module demux_main
    import demux_main_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              valid_out2,
    output logic              valid_out3,
    output logic              flushed
);
    if (FLUSH_CYCLES < 2 || FLUSH_CYCLES > 255) begin : g_bad_flush
        $error("FLUSH_CYCLES out of range 2..255");
    end

    state_t                        state, state_nx;
    logic [1:0]                    idx;
    logic [LANES-2:0][DATA_W-1:0]  stage;     // slot 3 goes straight to the output
    logic [LANES-1:0][DATA_W-1:0]  data_q;
    logic [LANES-1:0]              vout_q;
    logic                          flushed_q;
    logic                          group_done;
    logic                          flush_fire;

    assign group_done = valid_in && (idx == 2'd3);

`ifdef DEMUX_FLUSH_EN
    logic expired;

    demux_flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (valid_in || flush_fire),
        .enable  ((state == ST_FILL) && !valid_in),
        .expired (expired)
    );

    // A byte arriving as the timer expires cancels the flush.
    assign flush_fire = expired && !valid_in && (state == ST_FILL);
`else
    assign flush_fire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_EMPTY: if (valid_in)                 state_nx = ST_FILL;
            ST_FILL:  if (group_done || flush_fire) state_nx = ST_EMPTY;
            default:                                state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            idx       <= '0;
            stage     <= '0;
            data_q    <= '0;
            vout_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state     <= state_nx;
            vout_q    <= '0;
            flushed_q <= 1'b0;
            if (valid_in) begin
                idx <= idx + 2'd1;
                if (group_done) begin
                    data_q <= {data_in, stage};
                    vout_q <= '1;
                end else begin
                    for (int k = 0; k < LANES-1; k++)
                        if (idx == 2'(k)) stage[k] <= data_in;
                end
            end else if (flush_fire) begin
                // Only filled lanes are updated; the rest keep their last byte.
                for (int k = 0; k < LANES-1; k++) begin
                    if (2'(k) < idx) begin
                        data_q[k] <= stage[k];
                        vout_q[k] <= 1'b1;
                    end
                end
                flushed_q <= 1'b1;
                idx       <= '0;
            end
        end
    end

    assign {data_out3, data_out2, data_out1, data_out0}     = data_q;
    assign {valid_out3, valid_out2, valid_out1, valid_out0} = vout_q;
    assign flushed = flushed_q;
endmodule

// File: tb/tb_demux_main.sv
module tb_demux_main;
    localparam int FC = 8;

    logic       clk = 1'b0;
    logic       reset, valid_in;
    logic [7:0] data_in;
    logic [7:0] d0, d1, d2, d3;
    logic       v0, v1, v2, v3, flushed;

    always #5 clk = ~clk;

    demux_main #(.DATA_W(8), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .data_out0(d0), .data_out1(d1), .data_out2(d2), .data_out3(d3),
        .valid_out0(v0), .valid_out1(v1), .valid_out2(v2), .valid_out3(v3),
        .flushed(flushed)
    );

    typedef struct {
        int             cyc;
        logic [3:0][7:0] d;
        logic [3:0]     m;
        logic           fl;
        logic           rst;
    } rec_t;

    rec_t       sb[$];
    int         vectors = 0, miscompares = 0;
    int         ecount = 0, pcount = 0;
    logic [7:0] grp[$];
    int         idle = 0;

    // Reference model: a group is just a list of bytes; emit when it holds four.
    task automatic model(input logic r, input logic v, input logic [7:0] d);
        rec_t e;
        e.cyc = ecount; e.d = '0; e.m = '0; e.fl = 1'b0; e.rst = 1'b0;
        if (r) begin
            grp.delete(); idle = 0; e.rst = 1'b1; sb.push_back(e);
        end else if (v) begin
            idle = 0;
            grp.push_back(d);
            if (grp.size() == 4) begin
                for (int k = 0; k < 4; k++) e.d[k] = grp[k];
                e.m = 4'hF;
                sb.push_back(e);
                grp.delete();
            end
        end else begin
`ifdef DEMUX_FLUSH_EN
            if (grp.size() > 0) begin
                if (idle == FC) begin
                    for (int k = 0; k < grp.size(); k++) begin
                        e.d[k] = grp[k]; e.m[k] = 1'b1;
                    end
                    e.fl = 1'b1;
                    sb.push_back(e);
                    grp.delete();
                    idle = 0;
                end else begin
                    idle++;
                end
            end
`endif
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset = r; valid_in = v; data_in = d;
        @(posedge clk);
        ecount++;
        model(r, v, d);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    // Monitor: every cycle compares against the queued record for that cycle,
    // or against "no emission, data held" when nothing is due.
    always @(posedge clk) pcount <= pcount + 1;

    logic [3:0][7:0] held = '0;
    always @(negedge clk) begin
        if (pcount > 0) begin
            rec_t e;
            logic [3:0][7:0] exp_d;
            logic [3:0][7:0] got_d;
            logic [3:0]      got_m;
            e.cyc = pcount; e.d = '0; e.m = '0; e.fl = 1'b0; e.rst = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == pcount) e = sb.pop_front();
            if (e.rst) held = '0;
            for (int k = 0; k < 4; k++) if (e.m[k]) held[k] = e.d[k];
            exp_d = held;
            got_d = {d3, d2, d1, d0};
            got_m = {v3, v2, v1, v0};
            vectors++;
            if (got_d !== exp_d || got_m !== e.m || flushed !== e.fl) begin
                miscompares++;
                $display("FAIL cyc%0d lanes: got data=%h valid=%b flushed=%b, want data=%h valid=%b flushed=%b",
                         pcount, got_d, got_m, flushed, exp_d, e.m, e.fl);
            end
        end
    end

    initial begin
        // reset state and basic group
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA0); step(1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b1, 8'hA2); step(1'b0, 1'b1, 8'hA3);
        idle_n(3);
        // back-to-back groups
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
        idle_n(2);
        // idle gap inside a group (below flush limit)
        step(1'b0, 1'b1, 8'h55); step(1'b0, 1'b1, 8'h66);
        idle_n(3);
        step(1'b0, 1'b1, 8'h77); step(1'b0, 1'b1, 8'h88);
        idle_n(2);
        // single byte then long idle: flush (if enabled) or silence
        step(1'b0, 1'b1, 8'h3C);
        idle_n(50);
        step(1'b0, 1'b1, 8'h4D); step(1'b0, 1'b1, 8'h4E);
        step(1'b0, 1'b1, 8'h4F);
        // byte arriving exactly at the flush limit cancels it
        idle_n(FC);
        step(1'b0, 1'b1, 8'h50);
        idle_n(2);
        // reset mid-group, reset beats valid_in
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01); step(1'b0, 1'b1, 8'h02);
        step(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h0A + i));
        idle_n(2);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) idle_n(FC + $urandom_range(0, 3));
            step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 55, 8'($urandom));
        end
        idle_n(FC + 4);
        @(negedge clk); #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending records, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
